// File: rtl/ret_addr_stack_pkg.sv
// Shared sizing for the return-address stack: default depth, address width
// and the derived pointer width.
package ret_addr_stack_pkg;

   localparam int RAS_DEPTH = 8;
   localparam int ADDR_W    = 16;
   localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

endpackage : ret_addr_stack_pkg

// File: rtl/ret_addr_stack_ras_storage.sv
// DEPTH x ADDR_W register array: one synchronous write port, one
// asynchronous read port.
module ras_storage
   import ret_addr_stack_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH,
   parameter int PTR_W = RAS_PTR_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [ADDR_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [ADDR_W-1:0] rdata_o
);

   logic [ADDR_W-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; validity is tracked by count in the parent,
   // so clearing it would only cost flops.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : ras_storage

// File: rtl/ret_addr_stack.sv
// Return-address stack: predicts JR R7 targets from JAL/JALR link addresses and
// flags a registered mispredict once the real target resolves in execute.
module ret_addr_stack
   import ret_addr_stack_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH,
   parameter int PTR_W = RAS_PTR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] top_addr_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [PTR_W:0]    count_o,
   input  logic              resolve_valid_i,
   input  logic [ADDR_W-1:0] resolve_target_i,
   output logic              mispredict_o,
   output logic              err_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]  tos_q, tos_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              pred_valid_q, pred_valid_d;
   logic [ADDR_W-1:0] pred_q, pred_d;
   logic              mispredict_q, mispredict_d;
   logic              err_q, err_d;

   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   logic [ADDR_W-1:0] mem_rdata;

   ras_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (push_addr_i),
      .raddr_i (tos_q),
      .rdata_o (mem_rdata)
   );

   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == FULL_CNT);
   assign count_o      = count_q;
   assign top_addr_o   = empty_o ? '0 : mem_rdata;
   assign mispredict_o = mispredict_q;
   assign err_o        = err_q;

   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      tos_d        = tos_q;
      count_d      = count_q;
      pred_valid_d = pred_valid_q;
      pred_d       = pred_q;
      mispredict_d = 1'b0;
      err_d        = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = tos_q;

      if (flush_i) begin
         tos_d        = '0;
         count_d      = '0;
         pred_valid_d = 1'b0;
      end else begin
         // Resolve consumes the old prediction before a same-cycle pop reloads it.
         if (resolve_valid_i && pred_valid_q) begin
            mispredict_d = (resolve_target_i != pred_q);
            pred_valid_d = 1'b0;
         end

         if (pop_i) begin
            pred_d       = top_addr_o;
            pred_valid_d = 1'b1;
            err_d        = empty_o || (pred_valid_q && !resolve_valid_i);
         end

         if (push_i && pop_i) begin
            mem_we    = 1'b1;
            mem_waddr = tos_q;
            if (empty_o) begin
               count_d = (PTR_W+1)'(1);
            end
         end else if (push_i) begin
            mem_we    = 1'b1;
            mem_waddr = tos_q + PTR_W'(1);
            tos_d     = tos_q + PTR_W'(1);
            if (!full_o) begin
               count_d = count_q + (PTR_W+1)'(1);
            end
         end else if (pop_i && !empty_o) begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - (PTR_W+1)'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tos_q        <= '0;
         count_q      <= '0;
         pred_valid_q <= 1'b0;
         pred_q       <= '0;
         mispredict_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         tos_q        <= tos_d;
         count_q      <= count_d;
         pred_valid_q <= pred_valid_d;
         pred_q       <= pred_d;
         mispredict_q <= mispredict_d;
         err_q        <= err_d;
      end
   end

endmodule : ret_addr_stack

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: expectations are queued with each stimulus
// step and drained against the DUT just after the following clock edge.
module tb_ret_addr_stack;

   typedef enum int {S_TOP, S_CNT, S_EMPTY, S_FULL, S_MIS, S_ERR} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [15:0] val;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        push;
   logic [15:0] push_addr;
   logic        pop;
   logic [15:0] top_addr;
   logic        empty;
   logic        full;
   logic [3:0]  count;
   logic        resolve_valid;
   logic [15:0] resolve_target;
   logic        mispredict;
   logic        err;

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb[$];

   ret_addr_stack dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush_i          (flush),
      .push_i           (push),
      .push_addr_i      (push_addr),
      .pop_i            (pop),
      .top_addr_o       (top_addr),
      .empty_o          (empty),
      .full_o           (full),
      .count_o          (count),
      .resolve_valid_i  (resolve_valid),
      .resolve_target_i (resolve_target),
      .mispredict_o     (mispredict),
      .err_o            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] observe(input sel_e s);
      case (s)
         S_TOP:   return top_addr;
         S_CNT:   return 16'(count);
         S_EMPTY: return 16'(empty);
         S_FULL:  return 16'(full);
         S_MIS:   return 16'(mispredict);
         default: return 16'(err);
      endcase
   endfunction

   task automatic exp_push(input string tag, input sel_e sel, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic drive(input logic ps, input logic [15:0] pa, input logic pp,
                        input logic rv, input logic [15:0] rt, input logic fl);
      push           = ps;
      push_addr      = pa;
      pop            = pp;
      resolve_valid  = rv;
      resolve_target = rt;
      flush          = fl;
   endtask

   // One clock: queue the pulse outputs expected after this edge, then compare.
   task automatic cycle(input string tag, input logic exp_mis, input logic exp_err);
      exp_push({tag, "_mis"}, S_MIS, 16'(exp_mis));
      exp_push({tag, "_err"}, S_ERR, 16'(exp_err));
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      drain();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      #12;
      exp_push("rst_cnt", S_CNT, 16'd0);
      exp_push("rst_empty", S_EMPTY, 16'd1);
      exp_push("rst_full", S_FULL, 16'd0);
      exp_push("rst_top", S_TOP, 16'h0);
      exp_push("rst_mis", S_MIS, 16'd0);
      exp_push("rst_err", S_ERR, 16'd0);
      drain();
      rst_n = 1'b1;

      // 1: three pushes, pop, correct resolve
      drive(1'b1, 16'h0102, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t1_push0", 1'b0, 1'b0);
      drive(1'b1, 16'h0204, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t1_push1", 1'b0, 1'b0);
      drive(1'b1, 16'h0306, 1'b0, 1'b0, 16'h0, 1'b0);
      exp_push("t1_cnt3", S_CNT, 16'd3);
      exp_push("t1_top3", S_TOP, 16'h0306);
      cycle("t1_push2", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      exp_push("t1_top_pop", S_TOP, 16'h0204);
      exp_push("t1_cnt_pop", S_CNT, 16'd2);
      cycle("t1_pop", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0306, 1'b0); cycle("t1_resolve", 1'b0, 1'b0);

      // 2: wrong resolve raises a single-cycle mispredict
      drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t2_push", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);    cycle("t2_pop", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0012, 1'b0); cycle("t2_resolve", 1'b1, 1'b0);
      cycle("t2_after", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      exp_push("t2_flush_cnt", S_CNT, 16'd0);
      exp_push("t2_flush_empty", S_EMPTY, 16'd1);
      cycle("t2_flush", 1'b0, 1'b0);

      // 3: overfill by one, drain eight, pop on empty
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 16'h1000 + 16'(2 * i), 1'b0, 1'b0, 16'h0, 1'b0);
         if (i == 8) begin
            exp_push("t3_full", S_FULL, 16'd1);
            exp_push("t3_cnt8", S_CNT, 16'd8);
            exp_push("t3_top_full", S_TOP, 16'h1010);
         end
         cycle($sformatf("t3_push%0d", i), 1'b0, 1'b0);
      end
      for (int j = 0; j < 8; j++) begin
         exp_push($sformatf("t3_top_before_pop%0d", j), S_TOP, 16'h1010 - 16'(2 * j));
         drain();
         drive(1'b0, 16'h0, 1'b1, (j > 0), 16'h1010 - 16'(2 * (j - 1)), 1'b0);
         cycle($sformatf("t3_pop%0d", j), 1'b0, 1'b0);
      end
      exp_push("t3_empty", S_EMPTY, 16'd1);
      exp_push("t3_cnt0", S_CNT, 16'd0);
      exp_push("t3_top0", S_TOP, 16'h0);
      drain();
      drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h1002, 1'b0); cycle("t3_pop_empty", 1'b0, 1'b1);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0); cycle("t3_resolve0", 1'b0, 1'b0);

      // 4: simultaneous push+pop replaces the top entry
      drive(1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t4_push", 1'b0, 1'b0);
      drive(1'b1, 16'h0B00, 1'b1, 1'b0, 16'h0, 1'b0);
      exp_push("t4_cnt", S_CNT, 16'd1);
      exp_push("t4_top", S_TOP, 16'h0B00);
      cycle("t4_pushpop", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0A00, 1'b0); cycle("t4_resolve", 1'b0, 1'b0);

      // 5: flush drops the outstanding prediction
      drive(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t5_push", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);    cycle("t5_pop", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      exp_push("t5_cnt", S_CNT, 16'd0);
      exp_push("t5_empty", S_EMPTY, 16'd1);
      cycle("t5_flush", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000, 1'b0); cycle("t5_resolve", 1'b0, 1'b0);

      // Second pop while a prediction is outstanding
      drive(1'b1, 16'h5000, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t7_push0", 1'b0, 1'b0);
      drive(1'b1, 16'h5002, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t7_push1", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);    cycle("t7_pop0", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);    cycle("t7_pop1", 1'b0, 1'b1);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h5000, 1'b0); cycle("t7_resolve", 1'b0, 1'b0);

      // 6: asynchronous reset between edges while err is high
      drive(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t6_push0", 1'b0, 1'b0);
      drive(1'b1, 16'h4002, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t6_push1", 1'b0, 1'b0);
      drive(1'b1, 16'h4004, 1'b0, 1'b0, 16'h0, 1'b0); cycle("t6_push2", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);    cycle("t6_pop0", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      exp_push("t6_cnt_pre", S_CNT, 16'd1);
      exp_push("t6_top_pre", S_TOP, 16'h4000);
      cycle("t6_pop1", 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_push("t6_rst_cnt", S_CNT, 16'd0);
      exp_push("t6_rst_empty", S_EMPTY, 16'd1);
      exp_push("t6_rst_top", S_TOP, 16'h0);
      exp_push("t6_rst_err", S_ERR, 16'd0);
      exp_push("t6_rst_mis", S_MIS, 16'd0);
      drain();
      #3;
      rst_n = 1'b1;
      cycle("t6_idle", 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4000, 1'b0); cycle("t6_resolve", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_ret_addr_stack

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Return-address stack that predicts JR R7 targets ahead of the register-indirect jump adder.
- Writer side: decode pushes the link address (PC+2) on JAL/JALR.
- Reader side: decode pops a predicted return target on JR.
- When the real Rs+imm target resolves in execute, it is compared against the popped prediction; a registered mispredict pulse is raised for the fetch redirect logic.

Parameters:
- DEPTH, 8, number of 16-bit entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH); width of the top-of-stack pointer.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  pipeline flush; empties stack and drops the outstanding prediction
- push  input  1  JAL/JALR in decode; push push_addr
- push_addr  input  16  link address (PC+2)
- pop  input  1  JR predicted as return; pop the top entry
- top_addr  output  16  current top entry (combinational from storage); 16'h0000 when empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  PTR_W+1  number of valid entries
- resolve_valid  input  1  execute has resolved the JR target
- resolve_target  input  16  actual Rs+imm target
- mispredict  output  1  registered one-cycle pulse: resolved target differs from prediction
- err  output  1  registered one-cycle pulse: pop on empty stack, or a new pop while a prediction is still outstanding

Behaviour:
- Reset (async, rst_n low):
  - tos=0, count=0, pred_valid=0, pred_reg=0.
  - mispredict=0, err=0, empty=1, full=0, top_addr=0.
  - Storage is not cleared.
- Storage: circular buffer mem[DEPTH]; tos points at the top entry; pointer arithmetic is mod DEPTH, wrapping naturally.
- Priority per cycle: flush > push/pop > resolve.
- flush: next state tos=0, count=0, pred_valid=0; push, pop and resolve that cycle are ignored; err=0, mispredict=0.
- push only:
  - tos<=tos+1; mem[tos+1]<=push_addr.
  - count<=min(count+1, DEPTH).
  - When full, the oldest entry is silently overwritten. This is not an error.
- pop only, count>0:
  - tos<=tos-1; count<=count-1.
  - pred_reg<=top_addr; pred_valid<=1.
- pop only, count==0:
  - err pulses next cycle; pointers unchanged.
  - pred_reg<=0; pred_valid<=1, so the prediction is 0 and any nonzero resolve mispredicts.
- push and pop together (JALR through R7):
  - Capture pred_reg<=top_addr, pred_valid<=1.
  - mem[tos]<=push_addr; tos and count unchanged.
  - If count==0: behaves as a push (count becomes 1) and err pulses.
- Outstanding prediction: a pop while pred_valid=1 and no same-cycle resolve pulses err, and the old prediction is overwritten.
- pop with resolve in the same cycle: resolve consumes the old prediction first; the pop then loads the new one. No err.
- resolve_valid with pred_valid=1:
  - mispredict<=(resolve_target != pred_reg) on the next edge.
  - pred_valid<=0 unless a pop in the same cycle reloads it.
- resolve_valid with pred_valid=0: ignored; no pulse.
- Latency:
  - top_addr reflects a push on the cycle after the edge.
  - mispredict and err assert the cycle after the causing event, for exactly one cycle.
- Width rules:
  - All addresses are 16-bit, no arithmetic on them.
  - count saturates at DEPTH and never underflows below 0.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Shared package: RAS_DEPTH default, ADDR_W=16, and the localparam for PTR_W derivation.
- One natural sub-module, ras_storage: DEPTH x 16 register array with one write port and one async read port (write addr, write data, write enable, read addr).
- Pointer, count, prediction and error logic stay in ret_addr_stack.

Test Plan:
1. Reset, then push 0x0102, 0x0204, 0x0306 -> count=3, top_addr=0x0306; pop -> top_addr=0x0204; resolve_target=0x0306 next cycle -> mispredict stays 0.
2. Push 0x0010; pop; resolve_target=0x0012 -> mispredict high exactly one cycle after the resolve.
3. Push 9 addresses 0x1000..0x1010 (step 2) with DEPTH=8 -> full=1, count=8; pop 8 times -> targets 0x1010 down to 0x1002, then empty=1; 9th pop -> err one-cycle pulse, predicted 0.
4. Push 0x0A00, then push+pop with push_addr=0x0B00 -> count stays 1, top_addr=0x0B00, pred_reg=0x0A00; resolve 0x0A00 -> no mispredict.
5. Push 0x2000, pop, then flush before resolve; resolve 0x3000 -> no mispredict, count=0, empty=1.
6. Push 0x4000, pop; assert rst_n=0 mid-cycle between edges -> count=0, empty=1 and outputs zero immediately; no err or mispredict after release.
